// File: rtl/shift_reg_checker.sv
// shift_reg_checker
//
// Self-checking monitor for a WIDTH-bit universal shift register. It watches
// the stimulus bus the DUT sees, keeps a cycle-accurate golden model of the
// register, and compares the DUT outputs against that model on every rising
// edge once it is synchronised.
//
// The DUT has no reset, so the monitor stays in IDLE until it sees a parallel
// load. That load defines the register contents. From then on the model tracks
// the DUT exactly.
//
// Parameters:
//   WIDTH        register width (model and Q compare width)
//   CNT_W        width of the saturating error/compare counters
//   STOP_ON_ERR  1: the first mismatch freezes the checker in FAIL
//
// Ports:
//   CLK          clock (the DUT updates on the same rising edge)
//   RESET_N      asynchronous active-low reset
//   ENB          observed enable, active high (0 = hold regardless of MODO)
//   DIR          observed direction: 0 = left (toward MSB), 1 = right
//   S_IN         observed serial input
//   MODO         observed mode: 00 shift, 01 rotate, 10 load, 11 hold
//   D            observed parallel data
//   Q            DUT parallel output
//   S_OUT        DUT serial output
//   ARMED        model synchronised; comparisons active
//   ERR          one-cycle pulse per mismatching compare
//   ERR_STICKY   set by any mismatch; cleared only by reset
//   ERR_CNT      number of mismatching compares (saturating)
//   CHK_CNT      number of compares performed (saturating)
//   EXP_Q        current model value
//   STATE        checker FSM state (debug): 0 IDLE, 1 ARMED, 2 FAIL

module shift_reg_checker #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] Q,
    input  logic             S_OUT,
    output logic             ARMED,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [WIDTH-1:0] EXP_Q,
    output logic [1:0]       STATE
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [WIDTH-1:0] model_q;
    logic             model_s;
    logic [WIDTH-1:0] next_q;
    logic             next_s;
    logic             mismatch;

    // Next model value from the stimulus sampled at this edge.
    always_comb begin
        next_q = model_q;
        next_s = model_s;
        if (ENB) begin
            case (MODO)
                MODE_SHIFT: begin
                    if (DIR) begin
                        next_q = {S_IN, model_q[WIDTH-1:1]};
                        next_s = model_q[0];
                    end else begin
                        next_q = {model_q[WIDTH-2:0], S_IN};
                        next_s = model_q[WIDTH-1];
                    end
                end
                MODE_ROTATE: begin
                    if (DIR) begin
                        next_q = {model_q[0], model_q[WIDTH-1:1]};
                        next_s = model_q[0];
                    end else begin
                        next_q = {model_q[WIDTH-2:0], model_q[WIDTH-1]};
                        next_s = model_q[WIDTH-1];
                    end
                end
                MODE_LOAD: begin
                    next_q = D;
                    next_s = 1'b0;
                end
                default: begin
                    next_q = model_q;
                    next_s = model_s;
                end
            endcase
        end
    end

    // Compared against the model built at the previous edge, so the check
    // trails the stimulus by exactly one clock.
    assign mismatch = (Q != model_q) || (S_OUT != model_s);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            model_q    <= '0;
            model_s    <= 1'b0;
            ERR        <= 1'b0;
            ERR_STICKY <= 1'b0;
            ERR_CNT    <= '0;
            CHK_CNT    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ERR <= 1'b0;
                    // The arming edge defines the contents; nothing to compare yet.
                    if (ENB && (MODO == MODE_LOAD)) begin
                        model_q <= D;
                        model_s <= 1'b0;
                        state   <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (CHK_CNT != CNT_MAX) CHK_CNT <= CHK_CNT + CNT_W'(1);
                    ERR <= mismatch;
                    if (mismatch) begin
                        ERR_STICKY <= 1'b1;
                        if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CNT_W'(1);
                        if (STOP_ON_ERR) state <= ST_FAIL;
                    end
                    model_q <= next_q;
                    model_s <= next_s;
                end
                ST_FAIL: begin
                    // Everything frozen except the ERR pulse, which drops.
                    ERR <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ARMED = (state != ST_IDLE);
    assign EXP_Q = model_q;
    assign STATE = state;

endmodule

// File: tb/tb_shift_reg_checker.sv
// Directed bench for shift_reg_checker. The bench plays the role of a correct
// shift register by driving Q/S_OUT with hand-computed values after each edge,
// and plants wrong values where a mismatch is wanted. Three checker instances
// share the bus: default parameters, CNT_W=2 (saturation), STOP_ON_ERR=1.

module tb_shift_reg_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enb = 1'b0;
    logic       dir = 1'b0;
    logic       s_in = 1'b0;
    logic [1:0] modo = 2'b11;
    logic [3:0] d = 4'h0;
    logic [3:0] q = 4'h0;
    logic       s_out = 1'b0;

    logic       armed_a, err_a, sticky_a;
    logic [7:0] err_cnt_a, chk_cnt_a;
    logic [3:0] exp_q_a;
    logic [1:0] state_a;

    logic       armed_b, err_b, sticky_b;
    logic [1:0] err_cnt_b, chk_cnt_b;
    logic [3:0] exp_q_b;
    logic [1:0] state_b;

    logic       armed_c, err_c, sticky_c;
    logic [7:0] err_cnt_c, chk_cnt_c;
    logic [3:0] exp_q_c;
    logic [1:0] state_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_reg_checker #(.WIDTH(4), .CNT_W(8), .STOP_ON_ERR(1'b0)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in),
        .MODO(modo), .D(d), .Q(q), .S_OUT(s_out),
        .ARMED(armed_a), .ERR(err_a), .ERR_STICKY(sticky_a),
        .ERR_CNT(err_cnt_a), .CHK_CNT(chk_cnt_a), .EXP_Q(exp_q_a), .STATE(state_a)
    );

    shift_reg_checker #(.WIDTH(4), .CNT_W(2), .STOP_ON_ERR(1'b0)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in),
        .MODO(modo), .D(d), .Q(q), .S_OUT(s_out),
        .ARMED(armed_b), .ERR(err_b), .ERR_STICKY(sticky_b),
        .ERR_CNT(err_cnt_b), .CHK_CNT(chk_cnt_b), .EXP_Q(exp_q_b), .STATE(state_b)
    );

    shift_reg_checker #(.WIDTH(4), .CNT_W(8), .STOP_ON_ERR(1'b1)) dut_c (
        .CLK(clk), .RESET_N(rst_n), .ENB(enb), .DIR(dir), .S_IN(s_in),
        .MODO(modo), .D(d), .Q(q), .S_OUT(s_out),
        .ARMED(armed_c), .ERR(err_c), .ERR_STICKY(sticky_c),
        .ERR_CNT(err_cnt_c), .CHK_CNT(chk_cnt_c), .EXP_Q(exp_q_c), .STATE(state_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive stimulus at the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic e, input logic dr, input logic si,
                        input logic [1:0] m, input logic [3:0] dd);
        @(negedge clk);
        enb  = e;
        dir  = dr;
        s_in = si;
        modo = m;
        d    = dd;
        @(posedge clk);
        #1;
    endtask

    // Emulated DUT outputs after an edge.
    task automatic dut_out(input logic [3:0] qq, input logic ss);
        q     = qq;
        s_out = ss;
    endtask

    initial begin
        // Reset state; Q left unknown as a real unreset register would be.
        q = 4'hx;
        s_out = 1'bx;
        #12;
        chk("rst_armed", armed_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_sticky", sticky_a, 0);
        chk("rst_err_cnt", err_cnt_a, 0);
        chk("rst_chk_cnt", chk_cnt_a, 0);
        chk("rst_exp_q", exp_q_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-load edges keep the checker idle.
        step(1, 0, 1, 2'b00, 4'h0);
        chk("idle_armed", armed_a, 0);
        chk("idle_chk_cnt", chk_cnt_a, 0);

        // Arm with load 0001; no compare on the arming edge.
        step(1, 0, 0, 2'b10, 4'b0001);
        dut_out(4'b0001, 0);
        chk("arm_armed", armed_a, 1);
        chk("arm_exp_q", exp_q_a, 4'b0001);
        chk("arm_chk_cnt", chk_cnt_a, 0);

        // Left shift x4, S_IN=0.
        step(1, 0, 0, 2'b00, 4'h0);
        dut_out(4'b0010, 0);
        chk("shl1_exp_q", exp_q_a, 4'b0010);
        chk("shl1_err", err_a, 0);
        chk("shl1_chk_cnt", chk_cnt_a, 1);
        step(1, 0, 0, 2'b00, 4'h0);
        dut_out(4'b0100, 0);
        chk("shl2_exp_q", exp_q_a, 4'b0100);
        step(1, 0, 0, 2'b00, 4'h0);
        dut_out(4'b1000, 0);
        chk("shl3_exp_q", exp_q_a, 4'b1000);
        step(1, 0, 0, 2'b00, 4'h0);
        dut_out(4'b0000, 1);
        chk("shl4_exp_q", exp_q_a, 4'b0000);
        chk("shl4_chk_cnt", chk_cnt_a, 4);

        // Load 0011 (this edge checks S_OUT=1 from the 4th shift).
        step(1, 0, 0, 2'b10, 4'b0011);
        dut_out(4'b0011, 0);
        chk("ld2_exp_q", exp_q_a, 4'b0011);
        chk("ld2_err", err_a, 0);

        // Right rotate x4.
        step(1, 1, 0, 2'b01, 4'h0);
        dut_out(4'b1001, 1);
        chk("rotr1_exp_q", exp_q_a, 4'b1001);
        step(1, 1, 0, 2'b01, 4'h0);
        dut_out(4'b1100, 1);
        chk("rotr2_exp_q", exp_q_a, 4'b1100);
        step(1, 1, 0, 2'b01, 4'h0);
        dut_out(4'b0110, 0);
        chk("rotr3_exp_q", exp_q_a, 4'b0110);
        step(1, 1, 0, 2'b01, 4'h0);
        dut_out(4'b0011, 0);
        chk("rotr4_exp_q", exp_q_a, 4'b0011);

        // ENB=0 holds for 3 edges even with MODO=rotate.
        step(0, 1, 1, 2'b01, 4'hF);
        chk("hold1_exp_q", exp_q_a, 4'b0011);
        step(0, 1, 1, 2'b01, 4'hF);
        step(0, 1, 1, 2'b01, 4'hF);
        chk("hold3_exp_q", exp_q_a, 4'b0011);
        chk("hold3_chk_cnt", chk_cnt_a, 12);
        chk("hold3_err_cnt", err_cnt_a, 0);
        chk("hold3_sticky", sticky_a, 0);

        // Load 0100, then present 0101 for one compare.
        step(1, 0, 0, 2'b10, 4'b0100);
        dut_out(4'b0100, 0);
        chk("ld3_exp_q", exp_q_a, 4'b0100);
        q = 4'b0101;
        step(0, 0, 0, 2'b00, 4'h0);
        dut_out(4'b0100, 0);
        chk("flt_err", err_a, 1);
        chk("flt_sticky", sticky_a, 1);
        chk("flt_err_cnt", err_cnt_a, 1);
        chk("flt_chk_cnt", chk_cnt_a, 14);
        chk("flt_stop_state", state_c, 2);
        chk("flt_stop_err", err_c, 1);
        step(0, 0, 0, 2'b00, 4'h0);
        chk("flt_after_err", err_a, 0);
        chk("flt_after_sticky", sticky_a, 1);
        chk("flt_after_err_cnt", err_cnt_a, 1);
        chk("stop_err_drop", err_c, 0);
        chk("stop_chk_frozen", chk_cnt_c, 14);

        // Shift left with S_IN=1: 0100 -> 1001; stop instance stays frozen.
        step(1, 0, 1, 2'b00, 4'h0);
        dut_out(4'b1001, 0);
        chk("shl_si_exp_q", exp_q_a, 4'b1001);
        chk("shl_si_err", err_a, 0);
        chk("shl_si_chk_cnt", chk_cnt_a, 16);
        chk("stop_exp_q_frozen", exp_q_c, 4'b0100);
        chk("stop_chk_frozen2", chk_cnt_c, 14);
        chk("stop_armed", armed_c, 1);
        chk("stop_sticky", sticky_c, 1);
        chk("sat_chk_cnt", chk_cnt_b, 3);
        chk("sat_err_cnt1", err_cnt_b, 1);

        // Persistent mismatch for 4 holds.
        q = 4'b0110;
        step(0, 0, 0, 2'b11, 4'h0);
        chk("pers1_err", err_a, 1);
        step(0, 0, 0, 2'b11, 4'h0);
        step(0, 0, 0, 2'b11, 4'h0);
        step(0, 0, 0, 2'b11, 4'h0);
        chk("pers4_err", err_a, 1);
        chk("pers4_err_cnt", err_cnt_a, 5);
        chk("pers4_chk_cnt", chk_cnt_a, 20);
        chk("sat_err_cnt", err_cnt_b, 3);
        chk("stop_err_cnt_frozen", err_cnt_c, 1);

        // Reset mid-shift, between edges.
        dut_out(4'b1001, 0);
        step(1, 1, 0, 2'b00, 4'h0);
        dut_out(4'b0100, 1);
        chk("pre_rst_exp_q", exp_q_a, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_armed", armed_a, 0);
        chk("mid_rst_err", err_a, 0);
        chk("mid_rst_sticky", sticky_a, 0);
        chk("mid_rst_err_cnt", err_cnt_a, 0);
        chk("mid_rst_chk_cnt", chk_cnt_a, 0);
        chk("mid_rst_exp_q", exp_q_a, 0);
        chk("mid_rst_stop_armed", armed_c, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // No compares until the next load, even with a wrong Q on the bus.
        q = 4'b1111;
        step(1, 0, 0, 2'b00, 4'h0);
        chk("rearm_idle_armed", armed_a, 0);
        chk("rearm_idle_chk", chk_cnt_a, 0);
        step(1, 0, 0, 2'b10, 4'b1010);
        dut_out(4'b1010, 0);
        chk("rearm_exp_q", exp_q_a, 4'b1010);
        chk("rearm_chk_cnt", chk_cnt_a, 0);
        chk("rearm_err", err_a, 0);

        // Mismatch on a load edge is still counted against the old model.
        q = 4'b0000;
        step(1, 0, 0, 2'b10, 4'b0111);
        dut_out(4'b0111, 0);
        chk("ldmis_err", err_a, 1);
        chk("ldmis_err_cnt", err_cnt_a, 1);
        chk("ldmis_exp_q", exp_q_a, 4'b0111);
        step(0, 0, 0, 2'b00, 4'h0);
        chk("ldmis_after_err", err_a, 0);
        chk("ldmis_after_chk", chk_cnt_a, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_reg_checker.md
Name: shift_reg_checker

Overview:
- Synthesizable self-checking monitor for the 4-bit universal shift register.
- Sits on the same bus as the stimulus generator and observes the stimulus (ENB, DIR, S_IN, MODO, D) and the DUT outputs (Q, S_OUT).
- Keeps a cycle-accurate golden model, compares the DUT against it every clock, and reports mismatches through flags and counters.
- Used in place of waveform inspection in all shift/rotate/load tests.

Parameters:
- WIDTH, 4, register width; model and Q compare width.
- CNT_W, 8, width of the error and compare counters (both saturating).
- STOP_ON_ERR, 0, when 1 the first mismatch freezes the checker in the FAIL state.

Ports:
- CLK  input  1  clock; the DUT register updates on the same rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- ENB  input  1  observed enable; active high.
- DIR  input  1  observed direction; 0 = left (toward MSB), 1 = right.
- S_IN  input  1  observed serial input.
- MODO  input  2  observed mode: 00 shift, 01 rotate, 10 parallel load, 11 hold.
- D  input  WIDTH  observed parallel data.
- Q  input  WIDTH  DUT parallel output.
- S_OUT  input  1  DUT serial output.
- ARMED  output  1  model synchronized; comparisons active.
- ERR  output  1  one-cycle pulse per mismatching compare.
- ERR_STICKY  output  1  set by any mismatch; cleared only by reset.
- ERR_CNT  output  CNT_W  number of mismatching compares.
- CHK_CNT  output  CNT_W  number of compares performed.
- EXP_Q  output  WIDTH  current model value (for debug and waveforms).

Behaviour:
- Reset (async, RESET_N=0):
  - State = IDLE.
  - Model Q = 0, model S_OUT = 0.
  - ARMED=0, ERR=0, ERR_STICKY=0, ERR_CNT=0, CHK_CNT=0, EXP_Q=0.
  - Reset mid-run discards all history; re-arm is required.
- States: IDLE -> ARMED -> FAIL.
  - FAIL exists only when STOP_ON_ERR=1.
  - ARMED output = (state != IDLE).
- IDLE:
  - The DUT has no reset, so its contents are unknown; no compares are made.
  - On the first edge with ENB=1 and MODO=10: model Q <= D, model S_OUT <= 0, go to ARMED.
  - All other edges: stay in IDLE, model unchanged.
- ARMED, at each rising edge, in this order using pre-edge values:
  - (1) Compare: mismatch = (Q != model Q) or (S_OUT != model S_OUT).
    - The model value compared is the one produced at the previous edge, so latency from stimulus edge to check is exactly 1 clock.
  - (2) Update counters and flags:
    - CHK_CNT += 1.
    - On mismatch: ERR <= 1, ERR_STICKY <= 1, ERR_CNT += 1.
    - Otherwise: ERR <= 0.
    - Both counters saturate at all-ones and never wrap.
  - (3) Update the model from ENB/MODO/DIR/S_IN/D sampled at this edge.
- Model update rules (ENB=0 means hold: Q and S_OUT unchanged, regardless of MODO):
  - Shift, left: Q <= {Q[W-2:0], S_IN}, S_OUT <= Q[W-1].
  - Shift, right: Q <= {S_IN, Q[W-1:1]}, S_OUT <= Q[0].
  - Rotate, left: Q <= {Q[W-2:0], Q[W-1]}, S_OUT <= Q[W-1].
  - Rotate, right: Q <= {Q[0], Q[W-1:1]}, S_OUT <= Q[0].
  - Load: Q <= D, S_OUT <= 0.
  - Hold (11): no change.
- FAIL (STOP_ON_ERR=1):
  - Entered on the same edge that registers the first mismatch.
  - Model, CHK_CNT and ERR_CNT freeze; ERR returns to 0 on the next edge.
  - ERR_STICKY stays 1 and ARMED stays 1.
  - Exit only by reset.
- Simultaneous events:
  - A mismatch on the edge that also loads D is still counted, because the compare uses the old model.
  - The arming edge itself performs no compare.
- EXP_Q always equals the model Q register.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then load: RESET_N low->high; edge with ENB=1, MODO=10, D=0001 -> ARMED=1; next edge compares Q=0001 -> ERR=0, CHK_CNT=1.
- Left shift: after load 0001, DIR=0, S_IN=0, MODO=00 for 4 edges -> EXP_Q sequence 0010, 0100, 1000, 0000; S_OUT expected 1 after the 4th shift; ERR_CNT=0 with a correct DUT.
- Right rotate: load 0011, DIR=1, MODO=01 -> EXP_Q 1001, 1100, 0110, 0011; then ENB=0 for 3 edges -> EXP_Q holds 0011.
- Injected fault: drive Q=0101 while EXP_Q=0100 for one cycle -> ERR pulses for exactly 1 cycle, ERR_STICKY=1, ERR_CNT=1; later matching cycles leave ERR=0.
- Saturation and stop: CNT_W=2, persistent mismatch -> ERR_CNT stops at 3; STOP_ON_ERR=1 -> CHK_CNT and EXP_Q freeze after the first error.
- Reset mid-shift: assert RESET_N=0 asynchronously between edges -> all outputs return to 0 immediately; no compares until the next parallel load.
